// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side drain engine. It pops async-FIFO words into a
//               2-entry buffer and presents them as a framed valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [1:0]       occ,
    output logic [CNTW-1:0]  word_cnt
);

    localparam logic [7:0] c_last_beat = 8'(BURST - 1);

    logic [DSIZE-1:0] r_slot [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_occ;
    logic [7:0]       r_beat;
    logic [CNTW-1:0]  r_word_cnt;

    logic w_push;
    logic w_pop;
    logic w_valid;

    // rinc sees only registered occupancy and rempty, never m_ready; reset
    // gating keeps the pop strobe low while rrst is held.
    assign w_push  = !rrst && !rempty && (r_occ < 2'd2);
    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid && m_ready;

    assign rinc     = w_push;
    assign m_valid  = w_valid;
    assign m_data   = r_slot[r_head];
    assign m_last   = w_valid && (r_beat == c_last_beat);
    assign occ      = r_occ;
    assign word_cnt = r_word_cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_slot[0]  <= '0;
            r_slot[1]  <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_occ      <= 2'd0;
            r_beat     <= 8'd0;
            r_word_cnt <= '0;
        end else begin
            if (w_push) begin
                r_slot[r_tail] <= rdata;
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head     <= ~r_head;
                r_word_cnt <= r_word_cnt + CNTW'(1);
                if (r_beat == c_last_beat) begin
                    r_beat <= 8'd0;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire
